// File: rtl/prio_arbiter_if.sv
// Request/grant bundle between N requesters and the priority arbiter.
interface prio_arbiter_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = $clog2(N)
);
  logic [N-1:0]     req;
  logic             mode_rr;
  logic             rel;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (output req, mode_rr, rel,
                  input  gnt, gnt_idx, gnt_valid, timeout);
  modport slave  (input  req, mode_rr, rel,
                  output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/prio_arbiter.sv
// Registered priority arbiter: fixed or round-robin selection over a
// highest-set-bit encoder, grant held until release, drop or hold limit.
module prio_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned IDX_W    = $clog2(N),
  parameter int unsigned MAX_HOLD = 0
) (
  input logic            clk,
  input logic            rst_n,
  prio_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0]     lower_req;
  logic [IDX_W-1:0] winner;
  logic             drop, at_limit;

  function automatic logic [IDX_W-1:0] highest_set(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) r = IDX_W'(i);
    return r;
  endfunction

  // Round-robin looks below the last winner first, then wraps from the top.
  always_comb begin
    lower_req = bus.req & ((N'(1) << ptr_q) - N'(1));
    if (bus.mode_rr && (|lower_req)) winner = highest_set(lower_req);
    else                             winner = highest_set(bus.req);
  end

  assign drop     = ~bus.req[idx_q];
  assign at_limit = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        if (|bus.req) begin
          state_d = GRANT;
          gnt_d   = N'(1) << winner;
          idx_d   = winner;
          valid_d = 1'b1;
          ptr_d   = winner;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (bus.rel || drop || at_limit) begin
          state_d   = IDLE;
          gnt_d     = '0;
          idx_d     = '0;
          valid_d   = 1'b0;
          cnt_d     = '0;
          timeout_d = at_limit && !bus.rel && !drop;
        end else if (!at_limit) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = timeout_q;

endmodule
